// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: frame constants, configuration enums, receiver
// state encoding and small helpers for normalising configuration inputs.
package uart_rx_deserializer_pkg;

   localparam int   DATA_WIDTH = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   typedef enum logic {
      EVEN_PARITY = 1'b0,
      ODD_PARITY  = 1'b1
   } PARITY_TYPE_E;

   typedef enum logic [4:0] {
      OVERSAMPLING_13 = 5'd13,
      OVERSAMPLING_16 = 5'd16
   } OVER_SAMPLING_E;

   typedef enum logic [1:0] {
      ONE_STOP_BIT = 2'd1,
      TWO_STOP_BIT = 2'd2
   } STOP_BIT_E;

   typedef enum logic [3:0] {
      DATA_5 = 4'd5,
      DATA_6 = 4'd6,
      DATA_7 = 4'd7,
      DATA_8 = 4'd8
   } DATA_TYPE_E;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } UART_RX_STATE_E;

   // Frame lengths outside 5..8 fall back to a full 8-bit frame.
   function automatic logic [3:0] normDataBits(input logic [3:0] cfg);
      return (cfg >= 4'd5 && cfg <= 4'd8) ? cfg : 4'd8;
   endfunction

   // Only an explicit request for two stop bits selects two; anything else is one.
   function automatic logic isTwoStop(input logic [1:0] cfg);
      return cfg == TWO_STOP_BIT;
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one-clock tick every CLK_PER_TICK clocks,
// held at phase zero while clear is asserted so a frame starts on a clean phase.
module uart_baud_tick_gen #(
   parameter int CLK_PER_TICK = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int            CW   = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next divider value: wraps at the last phase, forced to zero while cleared.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   // Divider register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises the rx pad, finds the start bit, samples data,
// parity and stop bits at mid-bit and hands complete frames to a consumer
// through a one-entry valid/ready holding register.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH   = uart_rx_deserializer_pkg::DATA_WIDTH,
   parameter int OVERSAMPLE   = 16,
   parameter int CLK_PER_TICK = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  rx_i,
   input  logic [3:0]            cfg_data_bits_i,
   input  logic                  cfg_parity_en_i,
   input  logic                  cfg_parity_odd_i,
   input  logic [1:0]            cfg_stop_bits_i,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic                  parity_err_o,
   output logic                  framing_err_o,
   output logic                  overrun_err_o,
   output logic                  busy_o
);

   localparam int               CNT_W    = $clog2(OVERSAMPLE);
   localparam int               IDX_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

   logic                  rx_meta_q;
   logic                  rx_s_q;
   UART_RX_STATE_E        state_q;
   logic                  armed_q;
   logic [CNT_W-1:0]      sample_cnt_q;
   logic [IDX_W-1:0]      bit_cnt_q;
   logic [IDX_W-1:0]      last_bit_q;
   logic                  par_en_q;
   logic                  par_odd_q;
   logic                  two_stop_q;
   logic                  stop_idx_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  perr_q;
   logic                  ferr_q;
   logic                  commit_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  parity_err_q;
   logic                  framing_err_q;
   logic                  overrun_err_q;
   logic                  tick;
   logic                  tick_clear;
   logic                  sample_now;

   assign tick_clear = (state_q == RX_IDLE);
   assign sample_now = tick && (sample_cnt_q == MID_CNT);

   uart_baud_tick_gen #(
      .CLK_PER_TICK(CLK_PER_TICK)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear_i(tick_clear),
      .tick_o (tick)
   );

   // Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high level.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Frame FSM: start detection, mid-bit sampling, parity/stop checks and commit strobe.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= RX_IDLE;
         armed_q      <= 1'b0;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         last_bit_q   <= '0;
         par_en_q     <= 1'b0;
         par_odd_q    <= 1'b0;
         two_stop_q   <= 1'b0;
         stop_idx_q   <= 1'b0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         commit_q     <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         if (state_q != RX_IDLE && tick) begin
            sample_cnt_q <= (sample_cnt_q == LAST_CNT) ? '0 : sample_cnt_q + CNT_W'(1);
         end
         case (state_q)
            RX_IDLE: begin
               sample_cnt_q <= '0;
               if (!armed_q) begin
                  armed_q <= rx_s_q;
               end else if (rx_s_q == START_BIT) begin
                  state_q    <= RX_START;
                  armed_q    <= 1'b0;
                  shift_q    <= '0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
                  bit_cnt_q  <= '0;
                  stop_idx_q <= 1'b0;
                  last_bit_q <= IDX_W'(normDataBits(cfg_data_bits_i) - 4'd1);
                  par_en_q   <= cfg_parity_en_i;
                  par_odd_q  <= cfg_parity_odd_i;
                  two_stop_q <= isTwoStop(cfg_stop_bits_i);
               end
            end
            RX_START: begin
               if (sample_now) begin
                  state_q <= (rx_s_q == START_BIT) ? RX_DATA : RX_IDLE;
               end
            end
            RX_DATA: begin
               if (sample_now) begin
                  shift_q[bit_cnt_q] <= rx_s_q;
                  if (bit_cnt_q == last_bit_q) begin
                     state_q <= par_en_q ? RX_PARITY : RX_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + IDX_W'(1);
                  end
               end
            end
            RX_PARITY: begin
               if (sample_now) begin
                  perr_q  <= (rx_s_q != ((^shift_q) ^ par_odd_q));
                  state_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (sample_now) begin
                  if (rx_s_q != STOP_BIT) begin
                     ferr_q <= 1'b1;
                  end
                  if (two_stop_q && !stop_idx_q) begin
                     stop_idx_q <= 1'b1;
                  end else begin
                     commit_q <= 1'b1;
                     state_q  <= RX_IDLE;
                  end
               end
            end
            default: begin
               state_q <= RX_IDLE;
            end
         endcase
      end
   end

   // Holding register: load on commit when free or being drained, else flag an overrun.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         overrun_err_q <= 1'b0;
         if (commit_q) begin
            if (!rx_valid_q || rx_ready_i) begin
               rx_data_q     <= shift_q;
               parity_err_q  <= perr_q;
               framing_err_q <= ferr_q;
               rx_valid_q    <= 1'b1;
            end else begin
               overrun_err_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign parity_err_o  = parity_err_q;
   assign framing_err_o = framing_err_q;
   assign overrun_err_o = overrun_err_q;
   assign busy_o        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: two instances (16x and 13x
// oversampling) driven with directed and randomised serial frames; expected
// bytes and error flags come from a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

   localparam int CPT = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } ExpFrame;

   logic       clk;
   logic       rst;
   logic       rxLine    [2];
   logic [3:0] cfgBits   [2];
   logic       cfgParEn  [2];
   logic       cfgParOdd [2];
   logic [1:0] cfgStop   [2];
   logic [7:0] rxData    [2];
   logic       rxValid   [2];
   logic       rxReady   [2];
   logic       parErr    [2];
   logic       frmErr    [2];
   logic       ovrErr    [2];
   logic       busy      [2];

   int bitPeriod [2] = '{16 * CPT, 13 * CPT};
   int ovrCount  [2] = '{0, 0};
   int checks = 0;
   int errors = 0;

   uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(16), .CLK_PER_TICK(CPT)) dut16 (
      .clk_i(clk), .reset_i(rst), .rx_i(rxLine[0]),
      .cfg_data_bits_i(cfgBits[0]), .cfg_parity_en_i(cfgParEn[0]),
      .cfg_parity_odd_i(cfgParOdd[0]), .cfg_stop_bits_i(cfgStop[0]),
      .rx_data_o(rxData[0]), .rx_valid_o(rxValid[0]), .rx_ready_i(rxReady[0]),
      .parity_err_o(parErr[0]), .framing_err_o(frmErr[0]),
      .overrun_err_o(ovrErr[0]), .busy_o(busy[0])
   );

   uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(13), .CLK_PER_TICK(CPT)) dut13 (
      .clk_i(clk), .reset_i(rst), .rx_i(rxLine[1]),
      .cfg_data_bits_i(cfgBits[1]), .cfg_parity_en_i(cfgParEn[1]),
      .cfg_parity_odd_i(cfgParOdd[1]), .cfg_stop_bits_i(cfgStop[1]),
      .rx_data_o(rxData[1]), .rx_valid_o(rxValid[1]), .rx_ready_i(rxReady[1]),
      .parity_err_o(parErr[1]), .framing_err_o(frmErr[1]),
      .overrun_err_o(ovrErr[1]), .busy_o(busy[1])
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count overrun pulses on both receivers.
   always @(posedge clk) begin
      if (ovrErr[0] === 1'b1) ovrCount[0]++;
      if (ovrErr[1] === 1'b1) ovrCount[1]++;
   end

   // Hard stop if the run wanders off.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got=timeout expected=completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: what the consumer should see for a frame built from these settings.
   function automatic ExpFrame modelFrame(input logic [7:0] data, input logic [3:0] cfgB,
                                          input logic parEn, input logic flipPar,
                                          input logic badStop);
      int n = (cfgB >= 4'd5 && cfgB <= 4'd8) ? int'(cfgB) : 8;
      ExpFrame f;
      f.data = data & 8'((1 << n) - 1);
      f.perr = parEn & flipPar;
      f.ferr = badStop;
      return f;
   endfunction

   task automatic driveBit(input int u, input logic b);
      rxLine[u] = b;
      repeat (bitPeriod[u]) @(negedge clk);
   endtask

   task automatic idleBits(input int u, input int n);
      rxLine[u] = 1'b1;
      repeat (n * bitPeriod[u]) @(negedge clk);
   endtask

   // Serialise one frame on receiver u using the line rules of the configuration.
   task automatic applyStimulus(input int u, input logic [7:0] data, input logic [3:0] cfgB,
                                input logic parEn, input logic parOdd, input logic [1:0] stopCfg,
                                input logic flipPar, input logic badStop);
      int   n  = (cfgB >= 4'd5 && cfgB <= 4'd8) ? int'(cfgB) : 8;
      int   ns = (stopCfg == 2'd2) ? 2 : 1;
      logic [7:0] masked = data & 8'((1 << n) - 1);
      cfgBits[u]   = cfgB;
      cfgParEn[u]  = parEn;
      cfgParOdd[u] = parOdd;
      cfgStop[u]   = stopCfg;
      driveBit(u, 1'b0);
      for (int i = 0; i < n; i++) driveBit(u, masked[i]);
      if (parEn) driveBit(u, 1'(($countones(masked) % 2) != 0) ^ parOdd ^ flipPar);
      for (int s = 0; s < ns; s++) driveBit(u, (badStop && s == ns - 1) ? 1'b0 : 1'b1);
      rxLine[u] = 1'b1;
   endtask

   // Wait (bounded) for a delivered frame, compare it, then accept it.
   task automatic expectFrame(input int u, input ExpFrame e, input string name);
      int waited = 0;
      while (rxValid[u] !== 1'b1 && waited < 4 * bitPeriod[u]) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({name, ".valid"}, 32'(rxValid[u]), 32'd1);
      checkOutput({name, ".data"}, 32'(rxData[u]), 32'(e.data));
      checkOutput({name, ".parityErr"}, 32'(parErr[u]), 32'(e.perr));
      checkOutput({name, ".framingErr"}, 32'(frmErr[u]), 32'(e.ferr));
      rxReady[u] = 1'b1;
      @(negedge clk);
      rxReady[u] = 1'b0;
      checkOutput({name, ".cleared"}, 32'(rxValid[u]), 32'd0);
   endtask

   task automatic sendAndCheck(input int u, input logic [7:0] data, input logic [3:0] cfgB,
                               input logic parEn, input logic parOdd, input logic [1:0] stopCfg,
                               input logic flipPar, input logic badStop, input string name);
      applyStimulus(u, data, cfgB, parEn, parOdd, stopCfg, flipPar, badStop);
      expectFrame(u, modelFrame(data, cfgB, parEn, flipPar, badStop), name);
      idleBits(u, 1);
   endtask

   initial begin
      int ovrBefore;
      int waited;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         rxLine[u] = 1'b1; rxReady[u] = 1'b0;
         cfgBits[u] = 4'd8; cfgParEn[u] = 1'b0; cfgParOdd[u] = 1'b0; cfgStop[u] = 2'd1;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checkOutput($sformatf("reset%0d.valid", u), 32'(rxValid[u]), 32'd0);
         checkOutput($sformatf("reset%0d.busy", u), 32'(busy[u]), 32'd0);
         checkOutput($sformatf("reset%0d.data", u), 32'(rxData[u]), 32'd0);
         checkOutput($sformatf("reset%0d.errs", u),
                     32'({parErr[u], frmErr[u], ovrErr[u]}), 32'd0);
      end
      rst = 1'b0;
      idleBits(0, 1);

      $display("[TB] directed frames");
      sendAndCheck(0, 8'hA5, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, "8N1_A5");
      sendAndCheck(0, 8'h41, 4'd7, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, "7E1_41");
      sendAndCheck(0, 8'h41, 4'd7, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, "7E1_41_flip");
      sendAndCheck(0, 8'h1F, 4'd5, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, "5O2_1F_badStop");
      sendAndCheck(0, 8'h03, 4'd5, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "5O2_03");

      $display("[TB] glitch rejection");
      for (int u = 0; u < 2; u++) begin
         rxLine[u] = 1'b0;
         repeat (3 * CPT) @(negedge clk);
         rxLine[u] = 1'b1;
         checkOutput($sformatf("glitch%0d.busyHigh", u), 32'(busy[u]), 32'd1);
         waited = 0;
         while (busy[u] !== 1'b0 && waited < bitPeriod[u]) begin
            @(negedge clk);
            waited++;
         end
         checkOutput($sformatf("glitch%0d.busyLow", u), 32'(busy[u]), 32'd0);
         idleBits(u, 1);
         checkOutput($sformatf("glitch%0d.noValid", u), 32'(rxValid[u]), 32'd0);
      end

      $display("[TB] overrun");
      ovrBefore = ovrCount[0];
      applyStimulus(0, 8'h11, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      applyStimulus(0, 8'h22, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      idleBits(0, 1);
      checkOutput("overrun.valid", 32'(rxValid[0]), 32'd1);
      checkOutput("overrun.keepsOld", 32'(rxData[0]), 32'h11);
      checkOutput("overrun.pulses", 32'(ovrCount[0] - ovrBefore), 32'd1);
      rxReady[0] = 1'b1;
      @(negedge clk);
      rxReady[0] = 1'b0;
      checkOutput("overrun.cleared", 32'(rxValid[0]), 32'd0);
      idleBits(0, 1);

      $display("[TB] reset mid-frame");
      for (int u = 0; u < 2; u++) begin
         cfgBits[u] = 4'd8; cfgParEn[u] = 1'b0; cfgStop[u] = 2'd1;
         driveBit(u, 1'b0);
         repeat (3) driveBit(u, 1'b1);
         checkOutput($sformatf("midReset%0d.busyBefore", u), 32'(busy[u]), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("midReset%0d.busyInReset", u), 32'(busy[u]), 32'd0);
         rst = 1'b0;
         idleBits(u, 8);
         checkOutput($sformatf("midReset%0d.noValid", u), 32'(rxValid[u]), 32'd0);
         checkOutput($sformatf("midReset%0d.idle", u), 32'(busy[u]), 32'd0);
         sendAndCheck(u, 8'h5A, 4'd8, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0,
                      $sformatf("midReset%0d.5A", u));
      end

      $display("[TB] randomised frames");
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 8; k++) begin
            logic [7:0] d    = 8'($urandom_range(0, 255));
            logic [3:0] b    = 4'($urandom_range(3, 10));
            logic       pe   = 1'($urandom_range(0, 1));
            logic       po   = 1'($urandom_range(0, 1));
            logic [1:0] sc   = 2'($urandom_range(0, 3));
            logic       flip = pe && ($urandom_range(0, 3) == 0);
            logic       bad  = ($urandom_range(0, 4) == 0);
            sendAndCheck(u, d, b, pe, po, sc, flip, bad, $sformatf("rand%0d_%0d", u, k));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
